// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants, types and helpers for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    // One prefetched instruction together with the PC+4 decode needs for it.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO with registered storage and no
//               write-to-read bypass. clr has priority over push and pop.
// Revision    : 1.0 - initial release
// Ports       : clk       in   clock, rising edge
//               rst       in   asynchronous reset, active-low
//               push      in   write push_data this cycle
//               push_data in   entry to write
//               pop       in   remove head (ignored when empty)
//               clr       in   empty the FIFO, overriding push/pop
//               count     out  number of stored entries
//               head      out  oldest entry (undefined when empty)
//               empty     out  no entries stored
// ============================================================================
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    input  logic                       clr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output T                           head,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_data;
    end

    // Issue credit in the parent must make this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !pop && !clr));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues word reads over a
//               req/gnt imem port with in-order variable-latency responses, and
//               buffers fetched words in a prefetch FIFO presented to decode.
//               Redirects flush the FIFO and discard in-flight responses.
// Revision    : 1.0 - initial release
// Ports       : clk          in   clock, rising edge
//               rst          in   asynchronous reset, active-low
//               stall_d      in   decode stalled, no pop this cycle
//               redirect     in   jump / j_src / taken branch from decode
//               redirect_pc  in   redirect target (bits [1:0] ignored)
//               imem_req     out  read request valid
//               imem_addr    out  word address of the request
//               imem_gnt     in   request accepted this cycle
//               imem_rvalid  in   response valid (in order)
//               imem_rdata   in   response data
//               instr        out  FIFO head instruction or NOP when empty
//               pc_plus4     out  FIFO head PC+4, zero when empty
//               fetch_valid  out  FIFO non-empty
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = FIFO_DEPTH[CNT_W:0];

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [31:0]      target_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] in_flight_after_rsp;
    logic [CNT_W:0]   credit_used;
    logic             grant;
    logic             accept;
    logic             fifo_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Every buffered word and every in-flight request holds a FIFO slot, so a
    // response always finds room even when decode is stalled.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
    // Gating with rst keeps the request low while reset is asserted.
    assign imem_req    = rst && !redirect && (credit_used < DEPTH_C);
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;

    // Responses to requests issued before a redirect are dropped until the
    // discard counter drains.
    assign accept      = imem_rvalid && (discard == '0);
    assign push_entry  = '{instr: imem_rdata, pc_plus4: resp_pc + 32'd4};
    assign target_pc   = word_align(redirect_pc);

    assign in_flight_after_rsp = outstanding - CNT_W'(imem_rvalid);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (push_entry),
        .pop       (!stall_d),
        .clr       (redirect),
        .count     (fifo_count),
        .head      (head),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            // No grant is possible this cycle; everything still in flight,
            // less a response arriving now, is stale.
            fetch_pc    <= target_pc;
            resp_pc     <= target_pc;
            outstanding <= in_flight_after_rsp;
            discard     <= in_flight_after_rsp;
        end else begin
            if (grant)  fetch_pc <= fetch_pc + 32'd4;
            if (accept) resp_pc  <= resp_pc + 32'd4;
            outstanding <= in_flight_after_rsp + CNT_W'(grant);
            if (imem_rvalid && (discard != '0)) discard <= discard - 1'b1;
        end
    end

    assign fetch_valid = !fifo_empty;
    assign instr       = fifo_empty ? NOP_INSTR : head.instr;
    assign pc_plus4    = fifo_empty ? 32'h0     : head.pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with an in-order imem
//               responder model and a golden decode-side PC sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        fetch_valid;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_d     (stall_d),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        rst_v;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc4;
    } vec_t;

    pend_t pend[$];
    int    cyc      = 0;
    int    last_due = 0;
    int    lat      = 1;
    bit    lat_rand = 1'b0;
    bit    gnt_rand = 1'b0;
    int    total    = 0;
    int    bad      = 0;

    logic        s_req, s_valid, s_gnt;
    logic [31:0] s_addr, s_instr, s_pc4;
    int          s_inflight;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic q,
                                input logic [31:0] a, input logic v,
                                input logic [31:0] p);
        vec_t t;
        t.rst_v = r; t.stall = s; t.exp_req = q;
        t.exp_addr = a; t.exp_valid = v; t.exp_pc4 = p;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (!v) begin
            pend.delete();
            last_due    = 0;
            imem_rvalid = 1'b0;
            imem_rdata  = JUNK;
        end
    endtask

    // Presents the next in-order response whose latency has elapsed.
    task automatic update_resp();
        if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = JUNK;
        end
        imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // One clock cycle: sample outputs on the falling edge, then advance the
    // responder model just after the rising edge.
    task automatic tick();
        int d;
        @(negedge clk);
        s_req      = imem_req;
        s_addr     = imem_addr;
        s_valid    = fetch_valid;
        s_instr    = instr;
        s_pc4      = pc_plus4;
        s_gnt      = imem_gnt;
        s_inflight = pend.size() + (imem_rvalid ? 1 : 0);
        @(posedge clk);
        cyc++;
        #1;
        if (rst && s_req && s_gnt) begin
            d = (cyc - 1) + (lat_rand ? int'($urandom_range(1, 5)) : lat);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{addr: s_addr, due: d});
        end
        update_resp();
    endtask

    task automatic apply_reset();
        set_rst(1'b0);
        stall_d  = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        set_rst(1'b1);
    endtask

    task automatic wait_visible(input int max_cycles, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick();
            if (s_valid) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: no fetch_valid within %0d cycles", name, max_cycles);
        end
    endtask

    initial begin
        vec_t        vecs[$];
        int          grants;
        int          pops;
        logic [31:0] exp_pc;

        rst = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = JUNK;

        // rst, stall, req, addr, valid, pc_plus4 (gnt=1, 1-cycle latency)
        vecs.push_back(mk(0, 0, 0, 32'd0,  0, 32'd0));
        vecs.push_back(mk(1, 0, 1, 32'd0,  0, 32'd0));
        vecs.push_back(mk(1, 0, 1, 32'd4,  0, 32'd0));
        vecs.push_back(mk(1, 0, 1, 32'd8,  1, 32'd4));
        vecs.push_back(mk(1, 0, 1, 32'd12, 1, 32'd8));
        vecs.push_back(mk(1, 0, 1, 32'd16, 1, 32'd12));
        vecs.push_back(mk(1, 0, 1, 32'd20, 1, 32'd16));
        // reset mid-stream, then stall held 10 cycles from reset release
        vecs.push_back(mk(0, 0, 0, 32'd0,  0, 32'd0));
        vecs.push_back(mk(0, 1, 0, 32'd0,  0, 32'd0));
        vecs.push_back(mk(1, 1, 1, 32'd0,  0, 32'd0));
        vecs.push_back(mk(1, 1, 1, 32'd4,  0, 32'd0));
        vecs.push_back(mk(1, 1, 1, 32'd8,  1, 32'd4));
        vecs.push_back(mk(1, 1, 1, 32'd12, 1, 32'd4));
        for (int k = 0; k < 6; k++) vecs.push_back(mk(1, 1, 0, 32'd16, 1, 32'd4));
        // release: drain in order, fetch resumes
        vecs.push_back(mk(1, 0, 0, 32'd16, 1, 32'd4));
        vecs.push_back(mk(1, 0, 1, 32'd16, 1, 32'd8));
        vecs.push_back(mk(1, 0, 1, 32'd20, 1, 32'd12));
        vecs.push_back(mk(1, 0, 1, 32'd24, 1, 32'd16));
        vecs.push_back(mk(1, 0, 1, 32'd28, 1, 32'd20));
        vecs.push_back(mk(1, 0, 1, 32'd32, 1, 32'd24));

        grants = 0;
        lat    = 1;
        for (int i = 0; i < vecs.size(); i++) begin
            set_rst(vecs[i].rst_v);
            stall_d = vecs[i].stall;
            tick();
            if (vecs[i].rst_v && vecs[i].stall && s_req && s_gnt) grants++;
            check($sformatf("v%0d_req", i),   32'(s_req),   32'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i),  s_addr,       vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_pc4", i),   s_pc4,        vecs[i].exp_pc4);
            check($sformatf("v%0d_instr", i), s_instr,
                  vecs[i].exp_valid ? mem_word(vecs[i].exp_pc4 - 32'd4) : 32'h0);
        end
        check("stall_grants", 32'(grants), 32'd4);

        // Redirect with two responses in flight.
        apply_reset();
        lat = 3;
        tick();
        tick();
        check("t3_inflight", 32'(pend.size()), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        tick();
        check("t3_req_redirect", 32'(s_req), 32'd0);
        redirect = 1'b0;
        wait_visible(20, "t3_wait");
        check("t3_pc4",   s_pc4,   32'h0000_0404);
        check("t3_instr", s_instr, mem_word(32'h0000_0400));

        // Redirect coinciding with a response, a push and a pop.
        apply_reset();
        lat = 2;
        for (int k = 0; k < 4; k++) tick();
        check("t4_pre_valid",  32'(fetch_valid), 32'd1);
        check("t4_pre_rvalid", 32'(imem_rvalid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_0800;
        tick();
        redirect = 1'b0;
        tick();
        check("t4_empty_valid", 32'(s_valid), 32'd0);
        check("t4_empty_instr", s_instr,      32'h0);
        check("t4_empty_pc4",   s_pc4,        32'h0);
        wait_visible(20, "t4_wait");
        check("t4_pc4",   s_pc4,   32'h0000_0804);
        check("t4_instr", s_instr, mem_word(32'h0000_0800));

        // Unaligned redirect near the top of the address space.
        apply_reset();
        lat = 1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        check("t5_req_redirect", 32'(s_req), 32'd0);
        redirect = 1'b0;
        tick();
        check("t5_req",   32'(s_req), 32'd1);
        check("t5_addr0", s_addr,     32'hFFFF_FFFC);
        tick();
        check("t5_addr1", s_addr,     32'h0000_0000);
        tick();
        check("t5_valid0", 32'(s_valid), 32'd1);
        check("t5_pc4_0",  s_pc4,        32'h0000_0000);
        check("t5_instr0", s_instr,      mem_word(32'hFFFF_FFFC));
        tick();
        check("t5_pc4_1",  s_pc4,        32'h0000_0004);
        check("t5_instr1", s_instr,      mem_word(32'h0000_0000));

        // Random latency, grant, stall and redirect with a mid-stream reset.
        lat_rand = 1'b1;
        gnt_rand = 1'b1;
        apply_reset();
        exp_pc = 32'h0;
        pops   = 0;
        for (int i = 0; i < 3000; i++) begin
            stall_d     = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom() & 32'h0003_FFFF;
            if (i == 1500 || i == 1501) begin
                set_rst(1'b0);
                redirect = 1'b0;
            end else begin
                set_rst(1'b1);
            end
            tick();
            if (!rst) begin
                check("t6_rst_req",   32'(s_req),   32'd0);
                check("t6_rst_valid", 32'(s_valid), 32'd0);
                check("t6_rst_pc4",   s_pc4,        32'h0);
                check("t6_rst_instr", s_instr,      32'h0);
                exp_pc = 32'h0;
            end else if (redirect) begin
                check("t6_req_redirect", 32'(s_req), 32'd0);
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (s_valid) begin
                check("t6_pc4",   s_pc4,   exp_pc + 32'd4);
                check("t6_instr", s_instr, mem_word(exp_pc));
                if (!stall_d) begin
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end
            total++;
            if (s_inflight > 4) begin
                bad++;
                $display("FAIL t6_credit: in-flight %0d exceeds limit 4", s_inflight);
            end
        end
        total++;
        if (pops < 200) begin
            bad++;
            $display("FAIL t6_progress: only %0d pops, need at least 200", pops);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
